// File: rtl/stage1_pkg.sv
// Shared constants for the stage 1 controller: opcodes, FSM state encodings,
// ALU operation codes, accumulator source select and instruction classes.
package stage1_pkg;

  // Opcodes (instr[7:4])
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDA  = 4'h1;
  localparam logic [3:0] OP_STA  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_MEM_RD = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM_WR = 3'd4;
  localparam logic [2:0] ST_BRANCH = 3'd5;
  localparam logic [2:0] ST_HALT   = 3'd6;

  // ALU operation codes
  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;
  localparam logic [2:0] ALU_NOT  = 3'd5;

  // Accumulator load source
  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_MEM = 2'd1;
  localparam logic [1:0] SRC_IMM = 2'd2;

  // Instruction classes produced by the decoder
  typedef enum logic [3:0] {
    CLS_NOP,
    CLS_MEMALU,
    CLS_STORE,
    CLS_UNARY,
    CLS_IMM,
    CLS_JUMP,
    CLS_JZ,
    CLS_HALT,
    CLS_ILLEGAL
  } instr_class_t;

endpackage

// File: rtl/stage1_decode.sv
// Combinational opcode decoder: maps IR[7:4] to an instruction class and
// the ALU operation used in EXEC.
module stage1_decode
  import stage1_pkg::*;
(
  input  logic [3:0]   opcode,
  output instr_class_t iclass,
  output logic [2:0]   alu_op
);

  // Opcode to class / ALU operation lookup
  always_comb begin
    iclass = CLS_ILLEGAL;
    alu_op = ALU_PASS;
    case (opcode)
      OP_NOP:  iclass = CLS_NOP;
      OP_LDA:  begin iclass = CLS_MEMALU; alu_op = ALU_PASS; end
      OP_STA:  iclass = CLS_STORE;
      OP_ADD:  begin iclass = CLS_MEMALU; alu_op = ALU_ADD;  end
      OP_SUB:  begin iclass = CLS_MEMALU; alu_op = ALU_SUB;  end
      OP_AND:  begin iclass = CLS_MEMALU; alu_op = ALU_AND;  end
      OP_OR:   begin iclass = CLS_MEMALU; alu_op = ALU_OR;   end
      OP_NOT:  begin iclass = CLS_UNARY;  alu_op = ALU_NOT;  end
      OP_LDI:  iclass = CLS_IMM;
      OP_JMP:  iclass = CLS_JUMP;
      OP_JZ:   iclass = CLS_JZ;
      OP_HALT: iclass = CLS_HALT;
      default: iclass = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/stage1.sv
// Stage 1 controller: accepts an instruction/data pair from stage 0 and
// sequences the accumulator datapath through a Moore FSM.
module stage1
  import stage1_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       stg0_state,
  input  logic [7:0] instr,
  input  logic [7:0] data,
  input  logic       acc_zero,
  output logic       stg1_state,
  output logic [7:0] mem_addr,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       acc_ld,
  output logic [1:0] acc_src,
  output logic [2:0] alu_op,
  output logic       pc_ld,
  output logic [7:0] pc_out,
  output logic       halted,
  output logic       illegal
);

  logic [2:0]   state_q, state_d;
  logic [7:0]   ir_q, dr_q;
  logic         accept;
  instr_class_t iclass;
  logic [2:0]   dec_alu_op;
  logic         unused_ir_lo;

  // Only the opcode nibble of IR drives control.
  assign unused_ir_lo = ^ir_q[3:0];

  assign accept = (state_q == ST_IDLE) && stg0_state;

  stage1_decode u_decode (
    .opcode (ir_q[7:4]),
    .iclass (iclass),
    .alu_op (dec_alu_op)
  );

  // State, instruction and operand registers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      dr_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ir_q <= instr;
        dr_q <= data;
      end
    end
  end

  // Next-state logic; acc_zero is only consulted while in DECODE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (stg0_state) state_d = ST_DECODE;
      ST_DECODE: begin
        case (iclass)
          CLS_MEMALU: state_d = ST_MEM_RD;
          CLS_STORE:  state_d = ST_MEM_WR;
          CLS_UNARY:  state_d = ST_EXEC;
          CLS_IMM:    state_d = ST_EXEC;
          CLS_JUMP:   state_d = ST_BRANCH;
          CLS_JZ:     state_d = acc_zero ? ST_BRANCH : ST_IDLE;
          CLS_HALT:   state_d = ST_HALT;
          default:    state_d = ST_IDLE;
        endcase
      end
      ST_MEM_RD: state_d = ST_EXEC;
      ST_EXEC:   state_d = ST_IDLE;
      ST_MEM_WR: state_d = ST_IDLE;
      ST_BRANCH: state_d = ST_IDLE;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the state, IR and DR registers only
  always_comb begin
    stg1_state = (state_q != ST_IDLE);
    mem_addr   = '0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    acc_ld     = 1'b0;
    acc_src    = SRC_ALU;
    alu_op     = ALU_PASS;
    pc_ld      = 1'b0;
    pc_out     = '0;
    halted     = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      ST_DECODE: illegal = (iclass == CLS_ILLEGAL);
      ST_MEM_RD: begin
        mem_rd   = 1'b1;
        mem_addr = dr_q;
      end
      ST_MEM_WR: begin
        mem_wr   = 1'b1;
        mem_addr = dr_q;
      end
      ST_EXEC: begin
        acc_ld = 1'b1;
        case (iclass)
          CLS_MEMALU: begin
            acc_src = (ir_q[7:4] == OP_LDA) ? SRC_MEM : SRC_ALU;
            alu_op  = dec_alu_op;
          end
          CLS_UNARY: begin
            acc_src = SRC_ALU;
            alu_op  = dec_alu_op;
          end
          CLS_IMM:   acc_src = SRC_IMM;
          default:   acc_src = SRC_ALU;
        endcase
      end
      ST_BRANCH: begin
        pc_ld  = 1'b1;
        pc_out = dr_q;
      end
      ST_HALT:   halted = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_stage1.sv
// Self-checking bench for stage1: table of single instructions plus
// hand-written reset, back-to-back, abort and HALT sequences.
module tb_stage1;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       stg0_state = 1'b0;
  logic [7:0] instr = '0;
  logic [7:0] data = '0;
  logic       acc_zero = 1'b0;
  logic       stg1_state, mem_rd, mem_wr, acc_ld, pc_ld, halted, illegal;
  logic [7:0] mem_addr, pc_out;
  logic [1:0] acc_src;
  logic [2:0] alu_op;

  stage1 dut (
    .clk        (clk),
    .clr        (clr),
    .stg0_state (stg0_state),
    .instr      (instr),
    .data       (data),
    .acc_zero   (acc_zero),
    .stg1_state (stg1_state),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .acc_ld     (acc_ld),
    .acc_src    (acc_src),
    .alu_op     (alu_op),
    .pc_ld      (pc_ld),
    .pc_out     (pc_out),
    .halted     (halted),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic       mem_wr;
    logic       acc_ld;
    logic [1:0] acc_src;
    logic [2:0] alu_op;
    logic       pc_ld;
    logic [7:0] pc_out;
    logic       halted;
    logic       illegal;
  } outs_t;

  typedef struct {
    string      name;
    logic [7:0] instr;
    logic [7:0] data;
    logic       az;
    int         n;
    outs_t      exp [3];
  } vec_t;

  outs_t sb [$];
  int    checks = 0;
  int    passes = 0;
  vec_t  tbl [15];

  function automatic outs_t o_idle();
    outs_t o = '0;
    return o;
  endfunction

  function automatic outs_t o_dec(logic ill);
    outs_t o = '0;
    o.busy = 1'b1; o.illegal = ill;
    return o;
  endfunction

  function automatic outs_t o_rd(logic [7:0] a);
    outs_t o = '0;
    o.busy = 1'b1; o.mem_rd = 1'b1; o.mem_addr = a;
    return o;
  endfunction

  function automatic outs_t o_wr(logic [7:0] a);
    outs_t o = '0;
    o.busy = 1'b1; o.mem_wr = 1'b1; o.mem_addr = a;
    return o;
  endfunction

  function automatic outs_t o_ld(logic [1:0] src, logic [2:0] op);
    outs_t o = '0;
    o.busy = 1'b1; o.acc_ld = 1'b1; o.acc_src = src; o.alu_op = op;
    return o;
  endfunction

  function automatic outs_t o_br(logic [7:0] a);
    outs_t o = '0;
    o.busy = 1'b1; o.pc_ld = 1'b1; o.pc_out = a;
    return o;
  endfunction

  function automatic outs_t o_halt();
    outs_t o = '0;
    o.busy = 1'b1; o.halted = 1'b1;
    return o;
  endfunction

  function automatic vec_t mkv(string nm, logic [7:0] i, logic [7:0] d, logic az,
                               int n, outs_t e0, outs_t e1, outs_t e2);
    vec_t v;
    v.name = nm; v.instr = i; v.data = d; v.az = az; v.n = n;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2;
    return v;
  endfunction

  function automatic outs_t capture();
    outs_t o;
    o.busy = stg1_state; o.mem_addr = mem_addr; o.mem_rd = mem_rd;
    o.mem_wr = mem_wr; o.acc_ld = acc_ld; o.acc_src = acc_src;
    o.alu_op = alu_op; o.pc_ld = pc_ld; o.pc_out = pc_out;
    o.halted = halted; o.illegal = illegal;
    return o;
  endfunction

  // Pop one expected output vector and compare it with the DUT right now.
  task automatic check_now(input string name, input int idx);
    outs_t exp_o, act_o;
    checks++;
    if (sb.size() == 0) begin
      $display("FAIL %s[%0d]: scoreboard empty, got %h", name, idx, capture());
    end else begin
      exp_o = sb.pop_front();
      act_o = capture();
      if (act_o === exp_o) passes++;
      else $display("FAIL %s[%0d]: got %h want %h", name, idx, act_o, exp_o);
    end
  endtask

  task automatic expect_cycles(input int n, input string name, input bit drop);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_now(name, i);
      if (drop && i == 0) stg0_state = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int budget = 0;
    while (stg1_state !== 1'b0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (budget < 20) passes++;
    else $display("FAIL %s_idle_timeout: got busy=%b want 0", name, stg1_state);
  endtask

  task automatic run_vec(input vec_t v);
    wait_idle(v.name);
    instr = v.instr; data = v.data; acc_zero = v.az; stg0_state = 1'b1;
    for (int k = 0; k < v.n; k++) sb.push_back(v.exp[k]);
    sb.push_back(o_idle());
    expect_cycles(v.n + 1, v.name, 1'b1);
  endtask

  initial begin
    tbl[0]  = mkv("nop",   8'h00, 8'h55, 1'b0, 1, o_dec(0), o_idle(), o_idle());
    tbl[1]  = mkv("lda",   8'h10, 8'h3C, 1'b0, 3, o_dec(0), o_rd(8'h3C), o_ld(2'd1, 3'd0));
    tbl[2]  = mkv("sta",   8'h20, 8'h80, 1'b0, 2, o_dec(0), o_wr(8'h80), o_idle());
    tbl[3]  = mkv("add",   8'h30, 8'h05, 1'b0, 3, o_dec(0), o_rd(8'h05), o_ld(2'd0, 3'd1));
    tbl[4]  = mkv("sub",   8'h40, 8'h11, 1'b0, 3, o_dec(0), o_rd(8'h11), o_ld(2'd0, 3'd2));
    tbl[5]  = mkv("and",   8'h5F, 8'h22, 1'b0, 3, o_dec(0), o_rd(8'h22), o_ld(2'd0, 3'd3));
    tbl[6]  = mkv("or",    8'h60, 8'hFF, 1'b0, 3, o_dec(0), o_rd(8'hFF), o_ld(2'd0, 3'd4));
    tbl[7]  = mkv("not",   8'h70, 8'h00, 1'b0, 2, o_dec(0), o_ld(2'd0, 3'd5), o_idle());
    tbl[8]  = mkv("ldi",   8'h80, 8'h9A, 1'b0, 2, o_dec(0), o_ld(2'd2, 3'd0), o_idle());
    tbl[9]  = mkv("jmp",   8'h90, 8'h17, 1'b0, 2, o_dec(0), o_br(8'h17), o_idle());
    tbl[10] = mkv("jz_t",  8'hA0, 8'h42, 1'b1, 2, o_dec(0), o_br(8'h42), o_idle());
    tbl[11] = mkv("jz_nt", 8'hA0, 8'h42, 1'b0, 1, o_dec(0), o_idle(), o_idle());
    tbl[12] = mkv("ill_b", 8'hB0, 8'h01, 1'b0, 1, o_dec(1), o_idle(), o_idle());
    tbl[13] = mkv("ill_c", 8'hC0, 8'h02, 1'b0, 1, o_dec(1), o_idle(), o_idle());
    tbl[14] = mkv("ill_e", 8'hE7, 8'h03, 1'b0, 1, o_dec(1), o_idle(), o_idle());

    // Reset held with a pending LDA: outputs stay zero, accept follows release
    instr = 8'h10; data = 8'h3C; stg0_state = 1'b1;
    repeat (3) sb.push_back(o_idle());
    expect_cycles(3, "reset", 1'b0);
    clr = 1'b1;
    sb.push_back(o_dec(0)); sb.push_back(o_rd(8'h3C));
    sb.push_back(o_ld(2'd1, 3'd0)); sb.push_back(o_idle());
    expect_cycles(4, "reset_lda", 1'b1);

    for (int i = 0; i < 15; i++) run_vec(tbl[i]);

    // ADD then STA offered back-to-back with stg0_state held high
    wait_idle("b2b");
    instr = 8'h30; data = 8'h05; stg0_state = 1'b1;
    sb.push_back(o_dec(0));
    expect_cycles(1, "b2b_add", 1'b0);
    instr = 8'h20; data = 8'h80;
    sb.push_back(o_rd(8'h05)); sb.push_back(o_ld(2'd0, 3'd1)); sb.push_back(o_idle());
    expect_cycles(3, "b2b_add_tail", 1'b0);
    sb.push_back(o_dec(0)); sb.push_back(o_wr(8'h80)); sb.push_back(o_idle());
    expect_cycles(3, "b2b_sta", 1'b1);

    // clr pulsed during MEM_RD of a SUB aborts it
    wait_idle("abort");
    instr = 8'h40; data = 8'h33; stg0_state = 1'b1;
    sb.push_back(o_dec(0)); sb.push_back(o_rd(8'h33));
    expect_cycles(2, "abort_sub", 1'b1);
    #2 clr = 1'b0;
    #1 sb.push_back(o_idle());
    check_now("abort_clr", 0);
    @(negedge clk);
    clr = 1'b1;
    sb.push_back(o_idle()); sb.push_back(o_idle());
    expect_cycles(2, "abort_after", 1'b0);

    // HALT is terminal; later transfers are ignored until clr
    wait_idle("halt");
    instr = 8'hF0; data = 8'h00; stg0_state = 1'b1;
    sb.push_back(o_dec(0));
    expect_cycles(1, "halt_dec", 1'b0);
    instr = 8'h00;
    repeat (4) sb.push_back(o_halt());
    expect_cycles(4, "halt_hold", 1'b0);
    #2 clr = 1'b0;
    #1 sb.push_back(o_idle());
    check_now("halt_clr", 0);
    @(negedge clk);
    clr = 1'b1; stg0_state = 1'b0;
    run_vec(tbl[0]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1);
  end

endmodule
